vga_sync_gen: RTL
=================

// Module: vga_sync_gen
// PURPOSE
//  Timing generator for the pong video path. Divides the system clock to a pixel
//  tick and runs horizontal/vertical pixel counters for 640x480@60 VGA.
//  Emits hsync/vsync, video_on and the current pixel coordinate x/y consumed by
//  pixel_gen, plus a per-frame pulse. Sits directly upstream of pixel_gen.
// PARAMETERS
//  CLK_DIV   4    system clocks per pixel tick (>=2); 100 MHz -> 25 MHz
//  H_DISPLAY 640  visible pixels per line
//  H_FRONT   16   horizontal front porch, pixels
//  H_SYNC    96   hsync width, pixels
//  H_BACK    48   horizontal back porch; H_TOTAL = sum = 800
//  V_DISPLAY 480  visible lines per frame
//  V_FRONT   10   vertical front porch, lines
//  V_SYNC    2    vsync width, lines
//  V_BACK    33   vertical back porch; V_TOTAL = sum = 525
//  SYNC_POL  0    asserted level of hsync/vsync (0 = active-low)
// PORTS
//  clk         in   1   system clock, all logic on rising edge
//  reset       in   1   synchronous, active-high reset
//  p_tick      out  1   one-clk pulse every CLK_DIV clks; counters advance on it
//  x           out  10  horizontal count 0..H_TOTAL-1 (registered)
//  y           out  10  vertical count 0..V_TOTAL-1 (registered)
//  video_on    out  1   high when x<H_DISPLAY and y<V_DISPLAY
//  hsync       out  1   horizontal sync, level SYNC_POL when asserted (registered)
//  vsync       out  1   vertical sync, level SYNC_POL when asserted (registered)
//  frame_tick  out  1   one-clk pulse on the p_tick that wraps (799,524)->(0,0)
// BEHAVIOUR
//  - Reset (sync, active-high): div=0, x=0, y=0, p_tick=0, frame_tick=0,
//    hsync=vsync=~SYNC_POL, video_on=1 (decoded from x=y=0). Reset wins over
//    every other event and may be applied mid-frame; the next clk after release
//    starts a new frame from (0,0).
//  - Divider: div counts 0..CLK_DIV-1 and wraps. p_tick is registered:
//    high for exactly one clk when div==CLK_DIV-1, i.e. every CLK_DIV clks.
//    First p_tick is CLK_DIV clks after reset release.
//  - Counters update only in the clk cycle where p_tick==1:
//    x==H_TOTAL-1 -> x=0 and y advances; else x=x+1.
//    y advances: y==V_TOTAL-1 -> y=0; else y=y+1. Hold when p_tick==0.
//  - hsync/vsync are registered from the NEXT x/y values so they change in the
//    same clk as x/y (zero skew vs coordinates):
//    hsync asserted for x in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] = 656..751
//    vsync asserted for y in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1] = 490..491
//  - video_on is combinational from registered x/y; no extra latency.
//  - frame_tick is registered together with the wrap: it is high in the clk
//    where x,y become (0,0) from (799,524); never asserted out of reset.
//  - y=481,x=0 occurs once per frame (vertical front porch); downstream uses it
//    as its 60 Hz refresh tick, so the counter sequence must be gap-free.
//  - Widths: x,y 10 bits; all comparisons unsigned; H_TOTAL,V_TOTAL <= 1024.
//  - Timing: line = 800 p_ticks = 3200 clks; frame = 525 lines = 1,680,000 clks.
// TESTING
//  1 reset held 5 clks then released -> x=y=0, hsync=vsync=1, video_on=1,
//    p_tick/frame_tick=0; first p_tick on clk 4 after release, then every 4th.
//  2 run one line -> x steps 0..799 on p_ticks, video_on drops at x=640,
//    hsync low exactly for x=656..751 (96 ticks), x=799 -> 0 with y 0 -> 1.
//  3 run one full frame -> vsync low only for y=490,491; video_on low for y>=480;
//    y 524 -> 0 with frame_tick one clk high; frame period 1,680,000 clks.
//  4 check y=481,x=0 seen exactly once per frame, hsync/vsync edges in same clk
//    as the x/y change that causes them.
//  5 assert reset at x=300,y=200 mid-div -> next clk x=y=0, div=0, syncs
//    deasserted; sequence after release identical to scenario 1.
//  6 CLK_DIV=2 instance -> p_tick every 2 clks, line = 1600 clks, same x/y/sync pattern.

Source files
------------

// File: rtl/vga_sync_gen.sv
// vga_sync_gen
//   Timing generator for the pong video path. Divides the system clock down to
//   a pixel tick and runs the horizontal/vertical pixel counters for
//   640x480@60 VGA by default. Emits hsync/vsync, video_on, the current pixel
//   coordinate and a per-frame pulse for pixel_gen.
//
// Ports
//   clk         in   1   system clock, rising edge
//   reset       in   1   synchronous, active-high reset
//   p_tick      out  1   one-clk pulse every CLK_DIV clks; counters advance on it
//   x           out  10  horizontal count 0..H_TOTAL-1
//   y           out  10  vertical count 0..V_TOTAL-1
//   video_on    out  1   high inside the visible window
//   hsync       out  1   horizontal sync, level SYNC_POL when asserted
//   vsync       out  1   vertical sync, level SYNC_POL when asserted
//   frame_tick  out  1   one-clk pulse when (x,y) wraps to (0,0)
module vga_sync_gen #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter bit          SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  output logic       p_tick,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_tick
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);

  logic [DIV_W-1:0] div;
  logic             tick_now;
  logic [9:0]       x_next;
  logic [9:0]       y_next;
  logic             wrap_now;

  assign tick_now = (div == DIV_LAST);
  assign wrap_now = tick_now && (x == H_LAST) && (y == V_LAST);

  // Next coordinate is computed combinationally so that the registered syncs
  // can be decoded from it and change in the same clk as x/y.
  always_comb begin
    x_next = x;
    y_next = y;
    if (tick_now) begin
      if (x == H_LAST) begin
        x_next = '0;
        y_next = (y == V_LAST) ? '0 : y + 10'd1;
      end else begin
        x_next = x + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div        <= '0;
      x          <= '0;
      y          <= '0;
      p_tick     <= 1'b0;
      frame_tick <= 1'b0;
      hsync      <= ~SYNC_POL;
      vsync      <= ~SYNC_POL;
    end else begin
      div        <= tick_now ? '0 : div + DIV_W'(1);
      p_tick     <= tick_now;
      x          <= x_next;
      y          <= y_next;
      frame_tick <= wrap_now;
      hsync      <= (x_next >= HS_FIRST && x_next <= HS_LAST) ? SYNC_POL : ~SYNC_POL;
      vsync      <= (y_next >= VS_FIRST && y_next <= VS_LAST) ? SYNC_POL : ~SYNC_POL;
    end
  end

  assign video_on = (x < H_VIS) && (y < V_VIS);

endmodule
